// File: rtl/rx_mod.sv
// rtl/rx_mod.sv - 8N1 UART receiver with OVS-times oversampling, overrun and framing-error flags
`timescale 1ns/1ps
module rx_mod #(
   parameter int OVS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic       rxd,
   input  logic       rd_en,
   output logic [7:0] dout,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int CW = $clog2(OVS);
   localparam logic [CW-1:0] MID  = CW'(OVS/2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_nxt;
   logic [1:0]      sync;
   logic            rxs;
   logic [1:0]      prime;
   logic            armed;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      idx, idx_nxt;
   logic [7:0]      shift, shift_nxt;
   logic            byte_ok, byte_bad;

   assign rxs     = sync[1];
   assign rx_busy = (state != IDLE);

   // prime marks when sync holds real line samples rather than its reset value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b11;
         prime <= 2'b00;
         armed <= 1'b0;
      end else begin
         sync  <= {sync[0], rxd};
         prime <= {prime[0], 1'b1};
         if (baud_tick && prime[1] && rxs)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shift <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_nxt = shift;
      byte_ok   = 1'b0;
      byte_bad  = 1'b0;
      if (baud_tick) begin
         case (state)
            IDLE: begin
               if (armed && !rxs) begin
                  state_nxt = START;
                  cnt_nxt   = '0;
               end
            end
            START: begin
               if (cnt == MID) begin
                  cnt_nxt   = '0;
                  idx_nxt   = '0;
                  state_nxt = rxs ? IDLE : DATA;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt_nxt        = '0;
                  shift_nxt[idx] = rxs;
                  if (idx == 3'd7) begin
                     idx_nxt   = '0;
                     state_nxt = STOP;
                  end else begin
                     idx_nxt = idx + 3'd1;
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
                  byte_ok   = rxs;
                  byte_bad  = !rxs;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // a capture on the same edge as rd_en takes precedence over the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout      <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= byte_bad;
         if (rd_en && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
         if (byte_ok) begin
            if (!rx_valid || rd_en) begin
               dout     <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_mod.sv
// tb/tb_rx_mod.sv - scoreboard bench for rx_mod: directed frames, errors, reset and skewed loopback
`timescale 1ns/1ps
module tb_rx_mod;

   localparam real BIT_NS = 160.0;

   logic       clk;
   logic       rst;
   logic       baud_tick;
   logic       rxd;
   logic       rd_en;
   logic [7:0] dout;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       rx_busy;

   typedef struct {
      bit         is_ferr;
      logic [7:0] data;
   } ev_t;

   ev_t q[$];
   int  n_pass = 0;
   int  n_total = 0;
   bit  tick_en = 1'b1;
   bit  auto_ack = 1'b0;
   int  ack_req = 0;

   rx_mod #(.OVS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .baud_tick (baud_tick),
      .rxd       (rxd),
      .rd_en     (rd_en),
      .dout      (dout),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .rx_busy   (rx_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         baud_tick = tick_en;
      end
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // monitor: pops the scoreboard on every byte capture and every frame error, and owns rd_en
   initial begin
      bit prev_valid = 1'b0;
      bit ferr_prev  = 1'b0;
      int ack_done   = 0;
      ev_t e;
      rd_en = 1'b0;
      forever begin
         @(negedge clk);
         rd_en = 1'b0;
         if (rst) begin
            prev_valid = 1'b0;
            ferr_prev  = 1'b0;
         end else begin
            if (ferr_prev) check_eq("ferr_width", frame_err, 0);
            if (frame_err) begin
               check_eq("ferr_expected", q.size() != 0, 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  check_eq("ferr_kind", e.is_ferr, 1);
               end
            end
            if (rx_valid && !prev_valid) begin
               check_eq("byte_expected", q.size() != 0, 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  check_eq("byte_kind", e.is_ferr, 0);
                  check_eq("byte_dout", dout, e.data);
               end
               if (auto_ack) rd_en = 1'b1;
            end
            if (ack_req != ack_done) begin
               ack_done = ack_req;
               rd_en    = 1'b1;
            end
            prev_valid = rx_valid;
            ferr_prev  = frame_err;
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
      @(negedge clk);
      #3;
      rxd = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         #(bit_ns);
      end
      rxd = stop_bit;
      #(bit_ns);
      rxd = 1'b1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      ev_t e;
      e.is_ferr = 1'b0;
      e.data    = b;
      q.push_back(e);
   endtask

   task automatic push_ferr();
      ev_t e;
      e.is_ferr = 1'b1;
      e.data    = 8'h00;
      q.push_back(e);
   endtask

   task automatic drain(input int max_clk);
      int n = 0;
      while (q.size() != 0 && n < max_clk) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         check_eq("drain_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic manual_ack();
      @(negedge clk);
      ack_req++;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_dout"}, dout, 8'h00);
      check_eq({tag, "_rx_valid"}, rx_valid, 0);
      check_eq({tag, "_frame_err"}, frame_err, 0);
      check_eq({tag, "_overrun"}, overrun, 0);
      check_eq({tag, "_rx_busy"}, rx_busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // line held low through reset release must not start a frame
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("no_arm_low_line", rx_busy, 0);
      rxd = 1'b1;
      repeat (20) @(negedge clk);

      // no ticks: a low line is ignored
      tick_en = 1'b0;
      rxd = 1'b0;
      repeat (50) @(negedge clk);
      check_eq("hold_no_tick", rx_busy, 0);
      rxd = 1'b1;
      repeat (5) @(negedge clk);
      tick_en = 1'b1;
      repeat (20) @(negedge clk);

      // nominal byte, explicit acknowledge
      auto_ack = 1'b0;
      push_byte(8'hA5);
      send_frame(8'hA5, 1'b1, BIT_NS);
      drain(200);
      check_eq("a5_valid", rx_valid, 1);
      check_eq("a5_dout", dout, 8'hA5);
      check_eq("a5_ferr", frame_err, 0);
      manual_ack();
      check_eq("a5_ack_valid", rx_valid, 0);

      // 4-tick glitch
      @(negedge clk);
      #3 rxd = 1'b0;
      #40 rxd = 1'b1;
      repeat (30) @(negedge clk);
      check_eq("glitch_busy", rx_busy, 0);
      check_eq("glitch_valid", rx_valid, 0);
      check_eq("glitch_overrun", overrun, 0);

      // framing error, then a good byte
      auto_ack = 1'b1;
      push_ferr();
      send_frame(8'h3C, 1'b0, BIT_NS);
      repeat (30) @(negedge clk);
      drain(50);
      check_eq("ferr_no_valid", rx_valid, 0);
      #(3 * BIT_NS);
      push_byte(8'h81);
      send_frame(8'h81, 1'b1, BIT_NS);
      drain(200);
      repeat (5) @(negedge clk);

      // back-to-back without acknowledge -> overrun
      auto_ack = 1'b0;
      push_byte(8'h11);
      send_frame(8'h11, 1'b1, BIT_NS);
      send_frame(8'h22, 1'b1, BIT_NS);
      drain(200);
      repeat (5) @(negedge clk);
      check_eq("ovr_dout", dout, 8'h11);
      check_eq("ovr_valid", rx_valid, 1);
      check_eq("ovr_flag", overrun, 1);
      manual_ack();
      check_eq("ovr_ack_valid", rx_valid, 0);
      check_eq("ovr_ack_flag", overrun, 0);

      // reset during data bit 4 of 8'hFF
      @(negedge clk);
      #3 rxd = 1'b0;
      #(BIT_NS);
      rxd = 1'b1;
      #(4 * BIT_NS + BIT_NS / 2);
      rst = 1'b1;
      #2;
      check_reset_outputs("midrst");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check_eq("midrst_idle", rx_busy, 0);
      auto_ack = 1'b1;
      push_byte(8'h5A);
      send_frame(8'h5A, 1'b1, BIT_NS);
      drain(200);

      // skewed loopback over all byte values
      for (int i = 0; i < 256; i++) begin
         push_byte(8'(i));
         send_frame(8'(i), 1'b1, (i < 128) ? BIT_NS * 1.03 : BIT_NS * 0.97);
      end
      drain(400);
      repeat (10) @(negedge clk);
      check_eq("loop_overrun", overrun, 0);
      check_eq("loop_valid", rx_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rx_mod.md
RX_MOD -- requirements
Module: rx_mod

Interface
REQ-001 Parameter: OVS, default 16, meaning baud_tick pulses per bit period (power of two, 8..64).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 baud_tick  input  1  single-clk enable pulse at OVS x baud rate.
REQ-005 rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rd_en  input  1  consumer acknowledge; clears rx_valid.
REQ-007 dout  output  8  last received byte, stable while rx_valid=1.
REQ-008 rx_valid  output  1  level, high from byte capture until rd_en.
REQ-009 frame_err  output  1  one-clk pulse, stop bit sampled low.
REQ-010 overrun  output  1  sticky, byte completed while rx_valid=1; cleared by rd_en.
REQ-011 rx_busy  output  1  high in any state other than IDLE.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-013 rxd SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-014 FSM states: IDLE, START, DATA, STOP; all transitions occur only on clk edges with baud_tick=1, except reset.
REQ-015 IDLE: on baud_tick with rxs=0, go to START with tick counter cleared.
REQ-016 START: on the baud_tick where counter reaches OVS/2-1 (mid-bit), rxs=0 -> DATA with counter and bit index cleared; rxs=1 -> IDLE (false start, no output, no error).
REQ-017 DATA: sample rxs every OVS ticks at mid-bit; shift into bit (bit index) of the shift register, LSB first; after bit index 7 -> STOP.
REQ-018 STOP: sample rxs at mid-bit after OVS ticks; then return to IDLE on the same edge, without waiting for the end of the stop bit.
REQ-019 Stop sampled 1 and rx_valid=0: dout <= shift register, rx_valid <= 1 on that same edge.
REQ-020 Stop sampled 1 and rx_valid=1: dout unchanged, new byte discarded, overrun <= 1.
REQ-021 Stop sampled 0: byte discarded, dout/rx_valid unchanged, frame_err high for exactly one clk; FSM returns to IDLE and only re-arms on a subsequent rxs=0 sample.
REQ-022 rd_en with rx_valid=1 SHALL clear rx_valid and overrun on the next edge; rd_en with rx_valid=0 is ignored.
REQ-023 Same-edge byte capture and rd_en: capture wins; rx_valid stays 1, dout takes the new byte, overrun not set.
REQ-024 Tick counter width SHALL be log2(OVS); bit index width 3 bits; no counter wraps outside its own state.
REQ-025 Without baud_tick the FSM SHALL hold its state indefinitely.
REQ-026 Latency: rx_valid rises on the clk edge of the stop-bit mid-sample tick, about 9.5 bit periods plus 2 clk after the falling start edge on rxd.

Reset
REQ-027 rst=1 SHALL force, asynchronously: state IDLE, counters 0, synchronizer flops 1, shift register 0, dout 8'h00, rx_valid 0, frame_err 0, overrun 0, rx_busy 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no output.
REQ-029 After deassertion the block SHALL accept a start bit only after rxs has been sampled high at least once.

Verification
REQ-030 OVS=16; send 8'hA5 at nominal rate -> dout=8'hA5, rx_valid=1, frame_err=0; rd_en pulse -> rx_valid=0 next edge.
REQ-031 rxd low glitch of 4 ticks on an idle line -> FSM returns to IDLE; rx_valid, frame_err and overrun stay 0.
REQ-032 Send 8'h3C with stop bit forced 0 -> frame_err pulses exactly 1 clk, rx_valid stays 0; following 8'h81 received correctly.
REQ-033 Send 8'h11 then 8'h22 back-to-back with no rd_en -> dout=8'h11, overrun=1; rd_en -> overrun=0, rx_valid=0.
REQ-034 Assert rst during data bit 4 of 8'hFF -> all outputs at reset values; next frame 8'h5A received intact.
REQ-035 Loopback with the transmitter, 256 bytes 8'h00..8'hFF, rd_en each byte, with +/-3% baud skew -> all bytes match, no errors.
